// File: rtl/enc_in_sched_if.sv
// Scheduler bus: varint FIFO head, raw-data FIFO head, and the registered output stream.
// master = FIFO/encoder side, slave = scheduler side.
interface enc_in_sched_if;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned STRB_W  = 4;
   localparam int unsigned INDEX_W = 10;

   logic               vf_empty;
   logic [DATA_W-1:0]  vf_data;
   logic [INDEX_W-1:0] vf_index;
   logic               vf_last;
   logic               vf_pop;

   logic               rf_empty;
   logic [DATA_W-1:0]  rf_data;
   logic [STRB_W-1:0]  rf_wstrb;
   logic [INDEX_W-1:0] rf_index;
   logic               rf_last;
   logic               rf_pop;

   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_data;
   logic [STRB_W-1:0]  out_wstrb;
   logic               out_sel;
   logic               out_last;
   logic [INDEX_W-1:0] out_index;

   modport master (
      output vf_empty, vf_data, vf_index, vf_last,
      input  vf_pop,
      output rf_empty, rf_data, rf_wstrb, rf_index, rf_last,
      input  rf_pop,
      input  out_valid, out_data, out_wstrb, out_sel, out_last, out_index,
      output out_ready
   );

   modport slave (
      input  vf_empty, vf_data, vf_index, vf_last,
      output vf_pop,
      input  rf_empty, rf_data, rf_wstrb, rf_index, rf_last,
      output rf_pop,
      output out_valid, out_data, out_wstrb, out_sel, out_last, out_index,
      input  out_ready
   );
endinterface

// File: rtl/enc_in_sched.sv
// Drains varint then raw-data FIFO words per record into one registered valid/ready stream.
// Optional head-index checking against the running record index: ENC_SCHED_CHECK_EN.
module enc_in_sched (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   enc_in_sched_if.slave  bus,
   output logic           busy,
   output logic           err
);
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned STRB_W  = 4;
   localparam int unsigned INDEX_W = 10;

   typedef enum logic [1:0] {S_IDLE, S_VARINT, S_RAW, S_ERR} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_out_valid;
   logic [DATA_W-1:0]    r_out_data;
   logic [STRB_W-1:0]    r_out_wstrb;
   logic                 r_out_sel;
   logic                 r_out_last;
   logic [INDEX_W-1:0]   r_out_index;
   logic [INDEX_W-1:0]   r_cur_index;
   logic                 r_busy;

   logic                 w_free;
   logic                 w_vf_idx_ok;
   logic                 w_rf_idx_ok;
   logic                 w_vf_pop;
   logic                 w_rf_pop;
   logic                 w_load;
   logic                 w_ld_sel;
   logic                 w_ld_last;
   logic [DATA_W-1:0]    w_ld_data;
   logic [STRB_W-1:0]    w_ld_wstrb;
   logic [INDEX_W-1:0]   w_ld_index;
   logic                 w_idx_inc;
   logic                 w_out_valid_nxt;

   assign w_free = !r_out_valid || bus.out_ready;

`ifdef ENC_SCHED_CHECK_EN
   logic r_err;
   assign w_vf_idx_ok = (bus.vf_index == r_cur_index);
   assign w_rf_idx_ok = (bus.rf_index == r_cur_index);
   assign err         = r_err;

   // Sticky until reset; set on the cycle the FSM refuses a mismatched head.
   always_ff @(posedge clk) begin
      if (reset) r_err <= 1'b0;
      else if (w_state_nxt == S_ERR) r_err <= 1'b1;
   end
`else
   assign w_vf_idx_ok = 1'b1;
   assign w_rf_idx_ok = 1'b1;
   assign err         = 1'b0;
`endif

   // Next state, pop strobes and output-register load selection.
   always_comb begin
      w_state_nxt = r_state;
      w_vf_pop    = 1'b0;
      w_rf_pop    = 1'b0;
      w_load      = 1'b0;
      w_ld_sel    = 1'b0;
      w_ld_last   = 1'b0;
      w_ld_data   = '0;
      w_ld_wstrb  = '1;
      w_ld_index  = '0;
      w_idx_inc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable) w_state_nxt = S_VARINT;
         end
         S_VARINT: begin
            if (w_free && !bus.vf_empty) begin
               if (!w_vf_idx_ok) begin
                  w_state_nxt = S_ERR;
               end else begin
                  w_vf_pop   = 1'b1;
                  w_load     = 1'b1;
                  w_ld_data  = bus.vf_data;
                  w_ld_index = bus.vf_index;
                  if (bus.vf_last) w_state_nxt = S_RAW;
               end
            end
         end
         S_RAW: begin
            if (w_free && !bus.rf_empty) begin
               if (!w_rf_idx_ok) begin
                  w_state_nxt = S_ERR;
               end else begin
                  w_rf_pop   = 1'b1;
                  w_load     = 1'b1;
                  w_ld_sel   = 1'b1;
                  w_ld_data  = bus.rf_data;
                  w_ld_wstrb = bus.rf_wstrb;
                  w_ld_index = bus.rf_index;
                  w_ld_last  = bus.rf_last;
                  if (bus.rf_last) begin
                     w_idx_inc   = 1'b1;
                     w_state_nxt = enable ? S_VARINT : S_IDLE;
                  end
               end
            end
         end
         S_ERR: begin
            w_state_nxt = S_ERR;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_out_valid_nxt = w_load || (r_out_valid && !bus.out_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cur_index <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_wstrb <= '0;
         r_out_sel   <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_index <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_busy      <= (w_state_nxt != S_IDLE) || w_out_valid_nxt;
         if (w_idx_inc) r_cur_index <= r_cur_index + INDEX_W'(1);
         // Payload only changes on a load, so it stays stable under backpressure.
         if (w_load) begin
            r_out_data  <= w_ld_data;
            r_out_wstrb <= w_ld_wstrb;
            r_out_sel   <= w_ld_sel;
            r_out_last  <= w_ld_last;
            r_out_index <= w_ld_index;
         end
      end
   end

   assign bus.vf_pop    = w_vf_pop;
   assign bus.rf_pop    = w_rf_pop;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_wstrb = r_out_wstrb;
   assign bus.out_sel   = r_out_sel;
   assign bus.out_last  = r_out_last;
   assign bus.out_index = r_out_index;
   assign busy          = r_busy;
endmodule

// File: tb/tb_enc_in_sched.sv
// Directed bench for enc_in_sched: queue-modelled FWFT FIFOs, vector table plus corner sequences.
module tb_enc_in_sched;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic enable;
   logic busy;
   logic err;

   enc_in_sched_if bus();

   enc_in_sched dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (bus),
      .busy   (busy),
      .err    (err)
   );

   typedef struct {
      logic [31:0] data;
      logic [9:0]  index;
      logic        last;
   } vword_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  wstrb;
      logic [9:0]  index;
      logic        last;
   } rword_t;

   typedef struct {
      logic        rdy;
      logic        vp;
      logic        rp;
      logic        v;
      logic [31:0] d;
      logic        sel;
      logic [3:0]  ws;
      logic        last;
      logic [9:0]  idx;
   } vec_t;

   vword_t vq[$];
   rword_t rq[$];
   vec_t   tbl[15];

   int   checks = 0;
   int   errors = 0;
   logic pv;
   logic pr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive_heads();
      bus.vf_empty = (vq.size() == 0);
      bus.vf_data  = (vq.size() > 0) ? vq[0].data  : 32'h0;
      bus.vf_index = (vq.size() > 0) ? vq[0].index : 10'd0;
      bus.vf_last  = (vq.size() > 0) ? vq[0].last  : 1'b0;
      bus.rf_empty = (rq.size() == 0);
      bus.rf_data  = (rq.size() > 0) ? rq[0].data  : 32'h0;
      bus.rf_wstrb = (rq.size() > 0) ? rq[0].wstrb : 4'h0;
      bus.rf_index = (rq.size() > 0) ? rq[0].index : 10'd0;
      bus.rf_last  = (rq.size() > 0) ? rq[0].last  : 1'b0;
   endtask

   task automatic push_v(input logic [31:0] d, input logic [9:0] idx, input logic l);
      vword_t w;
      w.data = d; w.index = idx; w.last = l;
      vq.push_back(w);
      drive_heads();
   endtask

   task automatic push_r(input logic [31:0] d, input logic [3:0] ws, input logic [9:0] idx,
                         input logic l);
      rword_t w;
      w.data = d; w.wstrb = ws; w.index = idx; w.last = l;
      rq.push_back(w);
      drive_heads();
   endtask

   // Sample pops mid-cycle, clock once, then advance the modelled FIFO heads.
   task automatic tick();
      @(negedge clk);
      pv = bus.vf_pop;
      pr = bus.rf_pop;
      chk("pop_exclusive", 32'(pv & pr), 32'h0);
      @(posedge clk);
      #1;
      if (pv && vq.size() > 0) vq.delete(0);
      if (pr && rq.size() > 0) rq.delete(0);
      drive_heads();
   endtask

   function automatic vec_t mk(input logic rdy, input logic vp, input logic rp, input logic v,
                               input logic [31:0] d, input logic sel, input logic [3:0] ws,
                               input logic last, input logic [9:0] idx);
      vec_t r;
      r.rdy = rdy; r.vp = vp; r.rp = rp; r.v = v; r.d = d;
      r.sel = sel; r.ws = ws; r.last = last; r.idx = idx;
      return r;
   endfunction

   logic [9:0] exp_idx;
   logic       saw_1023;
   logic       saw_wrap;

   initial begin
      // Record 0 and record 1 (record 1 exercises backpressure mid-varint).
      tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'h0, 1'b0, 10'd0);
      tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h11, 1'b0, 4'hF, 1'b0, 10'd0);
      tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h22, 1'b0, 4'hF, 1'b0, 10'd0);
      tbl[3]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'hA,  1'b1, 4'h3, 1'b0, 10'd0);
      tbl[4]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'hB,  1'b1, 4'hF, 1'b1, 10'd0);
      tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h31, 1'b0, 4'hF, 1'b0, 10'd1);
      for (int i = 6; i < 11; i++)
         tbl[i] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h31, 1'b0, 4'hF, 1'b0, 10'd1);
      tbl[11] = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h32, 1'b0, 4'hF, 1'b0, 10'd1);
      tbl[12] = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h33, 1'b0, 4'hF, 1'b0, 10'd1);
      tbl[13] = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h41, 1'b1, 4'hF, 1'b1, 10'd1);
      tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'h0, 1'b0, 10'd0);

      reset = 1'b1;
      enable = 1'b0;
      bus.out_ready = 1'b0;
      drive_heads();
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_data",  bus.out_data, 32'h0);
      chk("rst_wstrb", 32'(bus.out_wstrb), 32'h0);
      chk("rst_sel",   32'(bus.out_sel), 32'h0);
      chk("rst_last",  32'(bus.out_last), 32'h0);
      chk("rst_index", 32'(bus.out_index), 32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_err",   32'(err), 32'h0);
      chk("rst_pops",  32'({bus.vf_pop, bus.rf_pop}), 32'h0);
      chk("rst_cur",   32'(dut.r_cur_index), 32'h0);

      push_v(32'h11, 10'd0, 1'b0);
      push_v(32'h22, 10'd0, 1'b1);
      push_r(32'hA, 4'h3, 10'd0, 1'b0);
      push_r(32'hB, 4'hF, 10'd0, 1'b1);
      push_v(32'h31, 10'd1, 1'b0);
      push_v(32'h32, 10'd1, 1'b0);
      push_v(32'h33, 10'd1, 1'b1);
      push_r(32'h41, 4'hF, 10'd1, 1'b1);
      enable = 1'b1;

      for (int i = 0; i < 15; i++) begin
         bus.out_ready = tbl[i].rdy;
         tick();
         chk($sformatf("row%0d_vpop", i), 32'(pv), 32'(tbl[i].vp));
         chk($sformatf("row%0d_rpop", i), 32'(pr), 32'(tbl[i].rp));
         chk($sformatf("row%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].v));
         if (tbl[i].v) begin
            chk($sformatf("row%0d_data", i),  bus.out_data, tbl[i].d);
            chk($sformatf("row%0d_sel", i),   32'(bus.out_sel), 32'(tbl[i].sel));
            chk($sformatf("row%0d_wstrb", i), 32'(bus.out_wstrb), 32'(tbl[i].ws));
            chk($sformatf("row%0d_last", i),  32'(bus.out_last), 32'(tbl[i].last));
            chk($sformatf("row%0d_index", i), 32'(bus.out_index), 32'(tbl[i].idx));
         end
      end
      chk("tbl_cur", 32'(dut.r_cur_index), 32'd2);
      chk("tbl_vq_empty", 32'(vq.size()), 32'd0);

      // Raw FIFO empty after varint last: RAW waits, later varint entries are not popped.
      push_v(32'h51, 10'd2, 1'b1);
      tick();
      chk("rw_vpop", 32'(pv), 32'h1);
      chk("rw_data", bus.out_data, 32'h51);
      push_v(32'h61, 10'd3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rw_wait%0d_pops", i), 32'({pv, pr}), 32'h0);
      end
      chk("rw_wait_valid", 32'(bus.out_valid), 32'h0);
      chk("rw_vq_kept", 32'(vq.size()), 32'd1);
      push_r(32'h71, 4'hF, 10'd2, 1'b1);
      tick();
      chk("rw_rpop", 32'(pr), 32'h1);
      chk("rw_rdata", bus.out_data, 32'h71);
      chk("rw_rlast", 32'(bus.out_last), 32'h1);
      chk("rw_rindex", 32'(bus.out_index), 32'd2);
      chk("rw_cur", 32'(dut.r_cur_index), 32'd3);

      // enable dropped after first varint word: record completes, then halt.
      tick();
      chk("en_v0", bus.out_data, 32'h61);
      enable = 1'b0;
      push_v(32'h62, 10'd3, 1'b1);
      push_r(32'h81, 4'h1, 10'd3, 1'b1);
      tick();
      chk("en_v1_pop", 32'(pv), 32'h1);
      chk("en_v1", bus.out_data, 32'h62);
      tick();
      chk("en_r_pop", 32'(pr), 32'h1);
      chk("en_r_wstrb", 32'(bus.out_wstrb), 32'h1);
      chk("en_r_busy", 32'(busy), 32'h1);
      tick();
      chk("en_drain_valid", 32'(bus.out_valid), 32'h0);
      chk("en_drain_busy", 32'(busy), 32'h0);
      push_v(32'hA1, 10'd4, 1'b1);
      tick();
      chk("en_idle_nopop", 32'(pv), 32'h0);
      chk("en_cur", 32'(dut.r_cur_index), 32'd4);

      // 1025 single-word records: index wraps 1023 -> 0 with no bubbles.
      for (int i = 0; i < 1025; i++) begin
         if (i > 0) push_v(32'(i), 10'(4 + i), 1'b1);
         push_r(32'h1000 + 32'(i), 4'hF, 10'(4 + i), 1'b1);
      end
      enable = 1'b1;
      exp_idx = 10'd4;
      saw_1023 = 1'b0;
      saw_wrap = 1'b0;
      for (int c = 0; c < 2200 && !(rq.size() == 0 && !bus.out_valid); c++) begin
         tick();
         if (bus.out_valid && bus.out_sel && bus.out_last) begin
            chk("wrap_index", 32'(bus.out_index), 32'(exp_idx));
            if (saw_1023 && bus.out_index == 10'd0) saw_wrap = 1'b1;
            saw_1023 = (bus.out_index == 10'd1023);
            exp_idx = exp_idx + 10'd1;
         end
      end
      chk("wrap_drained", 32'(rq.size()), 32'd0);
      chk("wrap_seen", 32'(saw_wrap), 32'h1);
      chk("wrap_cur", 32'(dut.r_cur_index), 32'd5);
      chk("wrap_err", 32'(err), 32'h0);

      // Raw head index 6 while the running index is 5.
      push_v(32'h91, 10'd5, 1'b1);
      push_r(32'h92, 4'hF, 10'd6, 1'b1);
      tick();
      chk("ix_vpop", 32'(pv), 32'h1);
      tick();
`ifdef ENC_SCHED_CHECK_EN
      chk("ix_no_rpop", 32'(pr), 32'h0);
      chk("ix_err", 32'(err), 32'h1);
      chk("ix_busy", 32'(busy), 32'h1);
      tick();
      chk("ix_err_hold_pops", 32'({pv, pr}), 32'h0);
      chk("ix_err_sticky", 32'(err), 32'h1);
      reset = 1'b1;
      vq.delete();
      rq.delete();
      drive_heads();
      tick();
      reset = 1'b0;
      chk("ix_rst_err", 32'(err), 32'h0);
      chk("ix_rst_busy", 32'(busy), 32'h0);
      chk("ix_rst_cur", 32'(dut.r_cur_index), 32'd0);
`else
      chk("ix_rpop", 32'(pr), 32'h1);
      chk("ix_err", 32'(err), 32'h0);
      chk("ix_data", bus.out_data, 32'h92);
      chk("ix_index", 32'(bus.out_index), 32'd6);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
